// File: rtl/teclado_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | teclado_pkg : shared types, keymap and reset constants for the   |
// |               4x4 keypad scanner (teclado_scan).                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package teclado_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [2:0] ROW_NONE = 3'd4;
  localparam logic [3:0] COLS_RST = 4'b1110;
  localparam logic [3:0] DATA_RST = 4'hF;
  localparam logic [3:0] KEY_STAR = 4'hE;

  // KEYMAP[row][col]; row 0 is the top row of the pad.
  localparam logic [0:3][0:3][3:0] KEYMAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Lowest-index active-low row wins; all high means no key.
  function automatic logic [2:0] row_code(input logic [3:0] rows_n);
    logic [2:0] code;
    code = ROW_NONE;
    if (!rows_n[0])      code = 3'd0;
    else if (!rows_n[1]) code = 3'd1;
    else if (!rows_n[2]) code = 3'd2;
    else if (!rows_n[3]) code = 3'd3;
    return code;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols_n);
    logic [1:0] idx;
    case (cols_n)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/teclado_tick.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | teclado_tick : divides clk by SCAN_DIV, one-clk tick on wrap.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module teclado_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int             CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/teclado_scan.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | teclado_scan : 4x4 keypad scanner, debouncer and key encoder.    |
// | Option TECLADO_CLEAR_KEY_EN: '*' clears the digit index.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module teclado_scan
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] data_filtrado,
  output logic [2:0] cifras_count,
  output logic       key_valid
);

  localparam int             DBW     = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_TICKS - 1);

  logic           w_tick;
  logic [3:0]     r_rows_meta;
  logic [3:0]     r_rows_sync;
  logic [2:0]     w_code;
  logic [3:0]     w_key;
  logic [2:0]     w_cif_inc;

  state_t         r_state,   w_state_nxt;
  logic [3:0]     r_cols,    w_cols_nxt;
  logic [2:0]     r_code,    w_code_nxt;
  logic [DBW-1:0] r_db,      w_db_nxt;
  logic [3:0]     r_data,    w_data_nxt;
  logic [2:0]     r_cif,     w_cif_nxt;
  logic           r_kv,      w_kv_nxt;

  teclado_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Rows come straight off the pad pins, asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rows_meta <= 4'hF;
      r_rows_sync <= 4'hF;
    end else begin
      r_rows_meta <= rows;
      r_rows_sync <= r_rows_meta;
    end
  end

  assign w_code    = row_code(r_rows_sync);
  assign w_key     = KEYMAP[r_code[1:0]][col_index(r_cols)];
  assign w_cif_inc = (r_cif >= 3'd4) ? 3'd1 : r_cif + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SCAN;
      r_cols  <= COLS_RST;
      r_code  <= ROW_NONE;
      r_db    <= '0;
      r_data  <= DATA_RST;
      r_cif   <= 3'd0;
      r_kv    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cols  <= w_cols_nxt;
      r_code  <= w_code_nxt;
      r_db    <= w_db_nxt;
      r_data  <= w_data_nxt;
      r_cif   <= w_cif_nxt;
      r_kv    <= w_kv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cols_nxt  = r_cols;
    w_code_nxt  = r_code;
    w_db_nxt    = r_db;
    w_data_nxt  = r_data;
    w_cif_nxt   = r_cif;
    w_kv_nxt    = 1'b0;

    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (w_code == ROW_NONE) begin
            w_cols_nxt = {r_cols[2:0], r_cols[3]};
          end else begin
            w_code_nxt  = w_code;
            w_db_nxt    = '0;
            w_state_nxt = ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          if (w_code != r_code) begin
            w_state_nxt = ST_SCAN;
          end else if (r_db == DB_LAST) begin
            w_kv_nxt    = 1'b1;
            w_state_nxt = ST_HOLD;
`ifdef TECLADO_CLEAR_KEY_EN
            if (w_key == KEY_STAR) begin
              w_data_nxt = DATA_RST;
              w_cif_nxt  = 3'd0;
            end else begin
              w_data_nxt = w_key;
              w_cif_nxt  = w_cif_inc;
            end
`else
            w_data_nxt = w_key;
            w_cif_nxt  = w_cif_inc;
`endif
          end else begin
            w_db_nxt = r_db + DBW'(1);
          end
        end

        ST_HOLD: begin
          if (w_code == ROW_NONE) begin
            w_db_nxt    = '0;
            w_state_nxt = ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (w_code != ROW_NONE) begin
            w_state_nxt = ST_HOLD;
          end else if (r_db == DB_LAST) begin
            w_cols_nxt  = {r_cols[2:0], r_cols[3]};
            w_state_nxt = ST_SCAN;
          end else begin
            w_db_nxt = r_db + DBW'(1);
          end
        end

        default: w_state_nxt = ST_SCAN;
      endcase
    end
  end

  assign cols          = r_cols;
  assign data_filtrado = r_data;
  assign cifras_count  = r_cif;
  assign key_valid     = r_kv;

endmodule
`default_nettype wire

// File: tb/tb_teclado_scan.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_teclado_scan : directed self-checking bench with a keypad     |
// |                   matrix model driving rows from cols.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_teclado_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] data_filtrado;
  logic [2:0] cifras_count;
  logic       key_valid;

  logic [3:0] pressed [4];
  int         cyc;
  int         kv_cnt = 0;
  int         total  = 0;
  int         bad    = 0;

  teclado_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rows          (rows),
    .cols          (cols),
    .data_filtrado (data_filtrado),
    .cifras_count  (cifras_count),
    .key_valid     (key_valid)
  );

  always #5 clk = ~clk;

  // Pad model: a row is pulled low when a pressed key sits on a driven column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) rows[r] = ~|(pressed[r] & ~cols);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt <= kv_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_kv(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press(input int r, input int c, input logic [3:0] exp_d,
                       input logic [2:0] exp_c, input string tag);
    int k0;
    bit f;
    k0 = kv_cnt;
    pressed[r][c] = 1'b1;
    wait_kv(80, f);
    chk({tag, " seen"}, 32'(f), 32'd1);
    chk({tag, " data"}, 32'(data_filtrado), 32'(exp_d));
    chk({tag, " cifras"}, 32'(cifras_count), 32'(exp_c));
    @(negedge clk);
    chk({tag, " pulse width"}, 32'(key_valid), 32'd0);
    repeat (30) @(negedge clk);
    chk({tag, " one pulse"}, 32'(kv_cnt - k0), 32'd1);
    pressed[r][c] = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    bit f;
    int k0;
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst cols", 32'(cols), 32'hE);
    chk("rst data", 32'(data_filtrado), 32'hF);
    chk("rst cifras", 32'(cifras_count), 32'd0);
    chk("rst kv", 32'(key_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle scan: column advances on every 4th edge after reset release.
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] exp_cols;
      @(negedge clk);
      exp_cols = ~(4'b0001 << ((k / 4) % 4));
      chk("idle cols", 32'(cols), 32'(exp_cols));
      chk("idle kv", 32'(key_valid), 32'd0);
    end
    chk("idle cifras", 32'(cifras_count), 32'd0);
    chk("idle data", 32'(data_filtrado), 32'hF);

    // Key 5: seen at tick 24, accepted at tick 36, released after edge 56.
    k0 = kv_cnt;
    pressed[1][1] = 1'b1;
    wait_kv(60, f);
    chk("k5 seen", 32'(f), 32'd1);
    chk("k5 latency", 32'(cyc), 32'd36);
    chk("k5 data", 32'(data_filtrado), 32'h5);
    chk("k5 cifras", 32'(cifras_count), 32'd1);
    chk("k5 cols", 32'(cols), 32'hD);
    step_to(56);
    chk("k5 hold cols", 32'(cols), 32'hD);
    pressed[1][1] = 1'b0;
    step_to(71);
    chk("k5 release cols", 32'(cols), 32'hD);
    step_to(72);
    chk("k5 rotate cols", 32'(cols), 32'hB);
    chk("k5 one pulse", 32'(kv_cnt - k0), 32'd1);

    // Digit index wraps 4 -> 1.
    do_reset();
    press(0, 0, 4'h1, 3'd1, "k1");
    press(0, 1, 4'h2, 3'd2, "k2");
    press(0, 2, 4'h3, 3'd3, "k3");
    press(0, 3, 4'hA, 3'd4, "kA");
    press(3, 1, 4'h0, 3'd1, "k0");

    // Bounce on key 9: low intervals too short for 4 consecutive ticks.
    k0 = kv_cnt;
    for (int i = 0; i < 7; i++) begin
      pressed[2][2] = ~pressed[2][2];
      repeat (3) @(negedge clk);
    end
    chk("bounce quiet", 32'(kv_cnt - k0), 32'd0);
    wait_kv(80, f);
    chk("bounce seen", 32'(f), 32'd1);
    chk("bounce data", 32'(data_filtrado), 32'h9);
    chk("bounce cifras", 32'(cifras_count), 32'd2);
    repeat (30) @(negedge clk);
    chk("bounce one pulse", 32'(kv_cnt - k0), 32'd1);
    pressed[2][2] = 1'b0;
    repeat (40) @(negedge clk);

    // Rows 0 and 2 on column 0: row 0 wins; then reset while holding.
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    wait_kv(80, f);
    chk("multi seen", 32'(f), 32'd1);
    chk("multi data", 32'(data_filtrado), 32'h1);
    chk("multi cifras", 32'(cifras_count), 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("hold rst cols", 32'(cols), 32'hE);
    chk("hold rst data", 32'(data_filtrado), 32'hF);
    chk("hold rst cifras", 32'(cifras_count), 32'd0);
    @(negedge clk);
    chk("hold rst kv", 32'(key_valid), 32'd0);
    chk("hold rst cols2", 32'(cols), 32'hE);
    pressed[0][0] = 1'b0;
    pressed[2][0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

`ifdef TECLADO_CLEAR_KEY_EN
    press(0, 2, 4'h3, 3'd1, "pre star");
    press(3, 0, 4'hF, 3'd0, "star clear");
    press(2, 1, 4'h8, 3'd1, "after star");
`else
    press(0, 2, 4'h3, 3'd1, "pre star");
    press(3, 0, 4'hE, 3'd2, "star digit");
    press(2, 1, 4'h8, 3'd3, "after star");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/teclado_scan.md
# teclado_scan

- Scans a 4x4 matrix keypad, debounces each press and encodes the key to a 4-bit value.
- Keeps a digit index 1..4 for the value just captured.
- Sits directly upstream of the four-digit display register stage in the keypad peripheral.
- Its `data_filtrado` and `cifras_count` outputs feed that stage's digit-data and digit-select inputs.

## Interface
- `SCAN_DIV`, 50000: clk cycles per scan tick (column dwell); minimum 2.
- `DEBOUNCE_TICKS`, 4: consecutive matching ticks required to accept a press or a release; minimum 1.
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `rows` in 4: keypad rows, active-low, pulled up, asynchronous to clk.
- `cols` out 4: column drive, one-cold active-low.
- `data_filtrado` out 4: encoded value of the last accepted key.
- `cifras_count` out 3: digit index of `data_filtrado`. 0 means none captured yet; otherwise 1..4.
- `key_valid` out 1: one-clk pulse when a key is accepted.

## Operation
- `rows` passes through a 2-flop synchronizer before any use. Row code = lowest-index low row; "none" if all rows are high.
- A tick counter counts 0..SCAN_DIV-1 and emits a one-clk tick on the wrap. All row sampling and FSM decisions happen only on ticks.
- Keymap, row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Digits encode to their value, A–D to 4'hA–4'hD, * to 4'hE, # to 4'hF.
- FSM states: SCAN, DEBOUNCE, HOLD, RELEASE.
  - SCAN: on tick, if the row code is "none", rotate `cols` (1110→1101→1011→0111→1110). Otherwise latch the row code, keep the column, clear the debounce counter and go to DEBOUNCE.
  - DEBOUNCE: on tick, if the row code equals the latched code, increment the counter. Otherwise return to SCAN without rotating.
    - When the counter reaches DEBOUNCE_TICKS: load `data_filtrado`, advance `cifras_count` (0→1, 1→2, 2→3, 3→4, 4→1), pulse `key_valid`, go to HOLD.
  - HOLD: column frozen. On a tick with row code "none", clear the counter and go to RELEASE.
  - RELEASE: on tick, "none" increments the counter; any press returns to HOLD.
    - When the counter reaches DEBOUNCE_TICKS, go to SCAN, rotating `cols` on that same tick.
- A held key produces exactly one `key_valid`; there is no auto-repeat. Keys pressed on other columns during HOLD or RELEASE are ignored.
- Two keys in the same column: the lower row wins. A second key on the same column arriving during DEBOUNCE changes the row code only if it is a lower row, which restarts the scan.
- Reset mid-operation returns everything to reset values immediately, including the tick counter, the FSM and the synchronizer.

## Timing
- Reset values:
  - `cols`=4'b1110
  - `data_filtrado`=4'hF (blank)
  - `cifras_count`=3'd0
  - `key_valid`=0
  - FSM=SCAN
  - tick counter=0
- Latency: `key_valid`, `data_filtrado` and `cifras_count` update together, registered, one clk after the tick that completes the debounce.
  - First detection tick T0, acceptance at tick T0+DEBOUNCE_TICKS.
  - Rows must be stable 2 clk before each sampling tick to be seen.
- `cols` changes only one clk after a tick. It is never rotated outside SCAN or the final RELEASE tick.
- Full scan period = 4*SCAN_DIV clk when idle.

## Configuration
- `TECLADO_CLEAR_KEY_EN` defined:
  - An accepted `*` does not load as a digit.
  - It forces `cifras_count`=0 and `data_filtrado`=4'hF and still pulses `key_valid`.
  - The next key becomes digit 1.
- Not defined: `*` loads 4'hE like any other key and advances the index.

## Structure
- `teclado_pkg`:
  - FSM state enum.
  - Keymap constant (4x4 array of 4-bit codes).
  - `ROW_NONE` code.
  - Reset constants for `cols` and `data_filtrado`.
- One sub-module, `teclado_tick`: parameterized SCAN_DIV divider with async reset, output `tick`.
- Synchronizer, FSM, debounce counter and digit counter stay in `teclado_scan`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_TICKS=3.
- Reset, no key: `cols` cycles 1110, 1101, 1011, 0111 every 4 clk. `cifras_count`=0, `data_filtrado`=F, `key_valid` never high.
- Press "5" (row1 low while `cols`=1101) held 40 clk:
  - One `key_valid` pulse 1 clk after the 3rd matching tick.
  - `data_filtrado`=5, `cifras_count`=1.
  - `cols` stays 1101 until 3 release ticks have passed.
- Keys 1, 2, 3, A, 0 pressed and released in order: `cifras_count` 1, 2, 3, 4, 1 with `data_filtrado` 1, 2, 3, A, 0.
- Bounce: row toggles every 3 clk for 20 clk, then goes stable. No `key_valid` during the bounce; exactly one after it settles.
- Rows 0 and 2 low together on `cols`=1110: `data_filtrado`=1. Also assert reset during HOLD: all outputs return to reset values the next clk.
- `*` press:
  - With `TECLADO_CLEAR_KEY_EN`: `cifras_count`=0, `data_filtrado`=F, `key_valid` pulses.
  - Without it: `data_filtrado`=E and `cifras_count` increments.
